// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared BrOp codes, BHT counter type and FSM states for the branch controller
//
// Purpose : constants and helpers used by branch_pc_ctrl and branch_bht.
// Contents: BrOp localparams, is_cond() classifier, bht_ctr_t / BHT_RESET,
//           run_state_e (IDLE/RUN sequencing state).

package branch_pkg;

  localparam logic [4:0] BR_BEQ  = 5'b01000;
  localparam logic [4:0] BR_BNE  = 5'b01001;
  localparam logic [4:0] BR_BLT  = 5'b01100;
  localparam logic [4:0] BR_BGE  = 5'b01101;
  localparam logic [4:0] BR_BLTU = 5'b01110;
  localparam logic [4:0] BR_BGEU = 5'b01111;
  localparam logic [4:0] BR_JAL  = 5'b10111;
  localparam logic [4:0] BR_JALR = 5'b10101;
  localparam logic [4:0] BR_NONE = 5'b11111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_RESET = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Every 01xxx code is a conditional branch.
  function automatic logic is_cond(input logic [4:0] brop);
    return brop[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// rtl/branch_bht.sv - direct-mapped table of 2-bit saturating branch history counters
//
// Purpose : branch history table with one combinational read port and one
//           synchronous saturating-update write port.
// Ports   : clk, rst_n          - clock, async active-low reset (all entries -> BHT_RESET)
//           i_rd_idx / o_rd_ctr - read index / counter value (pre-update in a same-index cycle)
//           i_wr_en             - apply an update this cycle
//           i_wr_idx            - entry to update
//           i_wr_taken          - 1: count up toward 2'b11, 0: count down toward 2'b00

module branch_bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_ctr_t         o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  bht_ctr_t r_ctr [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= BHT_RESET;
      end
    end else if (i_wr_en) begin
      if (i_wr_taken && (r_ctr[i_wr_idx] != 2'b11)) begin
        r_ctr[i_wr_idx] <= r_ctr[i_wr_idx] + 2'd1;
      end else if (!i_wr_taken && (r_ctr[i_wr_idx] != 2'b00)) begin
        r_ctr[i_wr_idx] <= r_ctr[i_wr_idx] - 2'd1;
      end
    end
  end

  // Reads the stored value, so a same-cycle update is not forwarded.
  assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/branch_pc_ctrl.sv
// rtl/branch_pc_ctrl.sv - fetch PC sequencer with ID-stage prediction and EX-stage branch resolution
//
// Purpose : owns the fetch PC; predicts conditional branches in ID from the BHT,
//           redirects on JAL in ID, and on mispredict/JALR in EX; keeps
//           saturating branch and mispredict counters.
// Ports   : clk, rst_n                       - clock, async active-low reset
//           stall                            - hold PC (EX redirect still wins)
//           id_valid/id_brop/id_pc/id_imm    - ID-stage instruction
//           ex_valid/ex_brop/ex_pc/ex_imm    - EX-stage instruction
//           ex_pred_taken, ex_branch_out     - prediction made in ID, actual outcome
//           ex_jalr_target                   - JALR target from the ALU
//           pc                               - registered fetch PC
//           id_pred_taken                    - ID redirect taken this cycle
//           flush_ifid, flush_idex           - squash pipeline registers this cycle
//           br_count, mispred_count          - saturating statistics

module branch_pc_ctrl
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [4:0]  id_brop,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic        ex_valid,
  input  logic [4:0]  ex_brop,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic        ex_branch_out,
  input  logic [31:0] ex_jalr_target,
  output logic [31:0] pc,
  output logic        id_pred_taken,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [15:0] br_count,
  output logic [15:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  run_state_e  r_state;
  logic [31:0] r_pc;
  logic [15:0] r_br_count;
  logic [15:0] r_mispred_count;

  logic        w_running;
  logic        w_ex_cond;
  logic        w_ex_jalr;
  logic        w_ex_redirect;
  logic [31:0] w_ex_target;
  logic        w_id_jal;
  logic        w_id_cond;
  bht_ctr_t    w_id_ctr;

  assign w_running = (r_state == ST_RUN);
  assign w_ex_cond = ex_valid & is_cond(ex_brop);
  assign w_ex_jalr = ex_valid & (ex_brop == BR_JALR);

  // Gated by w_running so every redirect/flush reads 0 in reset and IDLE.
  assign w_ex_redirect = w_running & ((w_ex_cond & (ex_branch_out != ex_pred_taken)) | w_ex_jalr);

  always_comb begin
    w_ex_target = ex_pc + 32'd4;
    if (w_ex_jalr) begin
      w_ex_target = ex_jalr_target & ~32'h1;
    end else if (ex_branch_out) begin
      w_ex_target = ex_pc + ex_imm;
    end
  end

  branch_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (id_pc[IDX_W+1:2]),
    .o_rd_ctr   (w_id_ctr),
    .i_wr_en    (w_running & w_ex_cond),
    .i_wr_idx   (ex_pc[IDX_W+1:2]),
    .i_wr_taken (ex_branch_out)
  );

  assign w_id_jal  = (id_brop == BR_JAL);
  assign w_id_cond = is_cond(id_brop);

  assign id_pred_taken = id_valid & ~stall & ~w_ex_redirect & w_running &
                         (w_id_jal | (w_id_cond & w_id_ctr[1]));
  assign flush_ifid    = w_ex_redirect | id_pred_taken;
  assign flush_idex    = w_ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_pc            <= RESET_PC;
      r_br_count      <= 16'd0;
      r_mispred_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_RUN;
          r_pc    <= RESET_PC;
        end
        default: begin
          if (w_ex_redirect) begin
            r_pc <= w_ex_target;
          end else if (id_pred_taken) begin
            r_pc <= id_pc + id_imm;
          end else if (!stall) begin
            r_pc <= r_pc + 32'd4;
          end
          if (w_ex_cond && (r_br_count != 16'hFFFF)) begin
            r_br_count <= r_br_count + 16'd1;
          end
          if (w_ex_redirect && (r_mispred_count != 16'hFFFF)) begin
            r_mispred_count <= r_mispred_count + 16'd1;
          end
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb/tb_branch_pc_ctrl.sv - self-checking bench for branch_pc_ctrl against a behavioural model

module tb_branch_pc_ctrl;

  localparam logic [4:0] C_BEQ  = 5'b01000;
  localparam logic [4:0] C_BNE  = 5'b01001;
  localparam logic [4:0] C_BLT  = 5'b01100;
  localparam logic [4:0] C_BGEU = 5'b01111;
  localparam logic [4:0] C_JAL  = 5'b10111;
  localparam logic [4:0] C_JALR = 5'b10101;
  localparam logic [4:0] C_NONE = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        id_valid;
  logic [4:0]  id_brop;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic        ex_valid;
  logic [4:0]  ex_brop;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic        ex_branch_out;
  logic [31:0] ex_jalr_target;
  logic [31:0] pc;
  logic        id_pred_taken;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  branch_pc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_brop        (id_brop),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .ex_valid       (ex_valid),
    .ex_brop        (ex_brop),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_branch_out  (ex_branch_out),
    .ex_jalr_target (ex_jalr_target),
    .pc             (pc),
    .id_pred_taken  (id_pred_taken),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: fetch PC, 16 history counters, statistics, started flag.
  logic [31:0] m_pc;
  int          m_bht [16];
  int          m_br;
  int          m_mis;
  bit          m_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_br  = 0;
    m_mis = 0;
    m_run = 1'b0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  task automatic clear_inputs();
    stall = 0; id_valid = 0; id_brop = C_NONE; id_pc = 0; id_imm = 0;
    ex_valid = 0; ex_brop = C_NONE; ex_pc = 0; ex_imm = 0;
    ex_pred_taken = 0; ex_branch_out = 0; ex_jalr_target = 0;
  endtask

  // Inputs are already driven; check same-cycle outputs, clock once, check state.
  task automatic step();
    bit          c_ex, j_ex, c_id, e_red, e_pred;
    int          ridx, widx;
    logic [31:0] e_tgt;
    #1;
    c_ex = ex_valid && (ex_brop[4:3] == 2'b01);
    j_ex = ex_valid && (ex_brop == C_JALR);
    c_id = (id_brop[4:3] == 2'b01);
    ridx = int'(id_pc[5:2]);
    widx = int'(ex_pc[5:2]);
    e_red  = m_run && ((c_ex && (ex_branch_out != ex_pred_taken)) || j_ex);
    if (j_ex) e_tgt = ex_jalr_target & 32'hFFFF_FFFE;
    else if (ex_branch_out) e_tgt = ex_pc + ex_imm;
    else e_tgt = ex_pc + 32'd4;
    e_pred = m_run && id_valid && !stall && !e_red &&
             ((id_brop == C_JAL) || (c_id && (m_bht[ridx] >= 2)));
    check_eq("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, e_pred});
    check_eq("flush_ifid", {31'd0, flush_ifid}, {31'd0, e_red || e_pred});
    check_eq("flush_idex", {31'd0, flush_idex}, {31'd0, e_red});
    if (!m_run) m_pc = 32'h0;
    else if (e_red) m_pc = e_tgt;
    else if (e_pred) m_pc = id_pc + id_imm;
    else if (!stall) m_pc = m_pc + 32'd4;
    if (m_run && c_ex) begin
      if (ex_branch_out) m_bht[widx] = (m_bht[widx] == 3) ? 3 : m_bht[widx] + 1;
      else m_bht[widx] = (m_bht[widx] == 0) ? 0 : m_bht[widx] - 1;
      if (m_br < 65535) m_br++;
    end
    if (e_red && (m_mis < 65535)) m_mis++;
    m_run = 1'b1;
    @(posedge clk);
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("br_count", {16'd0, br_count}, m_br);
    check_eq("mispred_count", {16'd0, mispred_count}, m_mis);
  endtask

  task automatic set_id(input logic [4:0] op, input logic [31:0] p, input logic [31:0] imm);
    id_valid = 1; id_brop = op; id_pc = p; id_imm = imm;
  endtask

  task automatic set_ex(input logic [4:0] op, input logic [31:0] p, input logic [31:0] imm,
                        input logic pred, input logic out, input logic [31:0] jt);
    ex_valid = 1; ex_brop = op; ex_pc = p; ex_imm = imm;
    ex_pred_taken = pred; ex_branch_out = out; ex_jalr_target = jt;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check_eq("reset pc", pc, 32'h0);
    check_eq("reset flushes", {30'd0, flush_ifid, flush_idex}, 32'h0);
    check_eq("reset counters", {br_count, mispred_count}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] ops [7];

  initial begin
    ops[0] = C_BEQ; ops[1] = C_BNE; ops[2] = C_BLT; ops[3] = C_BGEU;
    ops[4] = C_JAL; ops[5] = C_JALR; ops[6] = C_NONE;

    apply_reset();

    // Idle cycle then sequential fetch.
    step(); check_eq("seq idle", pc, 32'h0);
    step(); check_eq("seq 4", pc, 32'h4);
    step(); check_eq("seq 8", pc, 32'h8);
    step(); check_eq("seq 12", pc, 32'hC);

    // BEQ at 0x10: fresh counter predicts not taken, EX resolves taken.
    set_id(C_BEQ, 32'h10, 32'h20); #1;
    check_eq("beq fresh pred", {31'd0, id_pred_taken}, 32'd0);
    step(); clear_inputs();
    set_ex(C_BEQ, 32'h10, 32'h20, 1'b0, 1'b1, 32'h0); #1;
    check_eq("beq mispred flushes", {30'd0, flush_ifid, flush_idex}, 32'h3);
    step(); clear_inputs();
    check_eq("beq redirect pc", pc, 32'h30);
    check_eq("beq mispred count", {16'd0, mispred_count}, 32'd1);

    // Second BEQ: predicted taken in ID.
    set_id(C_BEQ, 32'h10, 32'h20); #1;
    check_eq("beq 2nd pred", {31'd0, id_pred_taken}, 32'd1);
    check_eq("beq 2nd flushes", {30'd0, flush_ifid, flush_idex}, 32'h2);
    step(); clear_inputs();
    check_eq("beq 2nd pc", pc, 32'h30);
    repeat (2) begin
      set_ex(C_BEQ, 32'h10, 32'h20, 1'b1, 1'b1, 32'h0);
      step(); clear_inputs();
    end
    // Saturated at 11: one not-taken must still leave it predicting taken.
    set_ex(C_BEQ, 32'h10, 32'h20, 1'b1, 1'b0, 32'h0);
    step(); clear_inputs();
    set_id(C_BEQ, 32'h10, 32'h20); #1;
    check_eq("beq saturated pred", {31'd0, id_pred_taken}, 32'd1);
    step(); clear_inputs();

    // JAL in ID, then JAL in EX, then JALR.
    set_id(C_JAL, 32'h40, 32'h100);
    step(); clear_inputs();
    check_eq("jal pc", pc, 32'h140);
    set_ex(C_JAL, 32'h40, 32'h100, 1'b1, 1'b0, 32'h0); #1;
    check_eq("jal in ex no flush", {30'd0, flush_ifid, flush_idex}, 32'h0);
    step(); clear_inputs();
    set_ex(C_JALR, 32'h150, 32'h0, 1'b0, 1'b0, 32'h203);
    step(); clear_inputs();
    check_eq("jalr pc", pc, 32'h202);

    // EX mispredict under stall with JAL in ID.
    stall = 1;
    set_id(C_JAL, 32'h60, 32'h40);
    set_ex(C_BNE, 32'h80, 32'h10, 1'b0, 1'b1, 32'h0); #1;
    check_eq("stall redirect pred", {31'd0, id_pred_taken}, 32'd0);
    step(); clear_inputs();
    check_eq("stall redirect pc", pc, 32'h90);

    // PC wrap.
    set_ex(C_JALR, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step(); clear_inputs();
    step();
    check_eq("pc wrap", pc, 32'h0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      stall    = ($urandom_range(0, 3) == 0);
      id_valid = $urandom_range(0, 1);
      id_brop  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 6)];
      id_pc    = {25'd0, 5'($urandom), 2'b00};
      id_imm   = $urandom;
      ex_valid = $urandom_range(0, 1);
      ex_brop  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 6)];
      ex_pc    = {25'd0, 5'($urandom), 2'b00};
      ex_imm   = $urandom;
      ex_pred_taken  = $urandom_range(0, 1);
      ex_branch_out  = $urandom_range(0, 1);
      ex_jalr_target = $urandom;
      step();
    end

    // Mid-operation reset.
    apply_reset();
    step();
    check_eq("post reset pc", pc, 32'h0);

    // Counter saturation.
    for (int n = 0; n < 70000; n++) begin
      clear_inputs();
      ex_valid = 1;
      ex_brop  = ops[$urandom_range(0, 3)];
      ex_pc    = {25'd0, 5'($urandom), 2'b00};
      ex_pred_taken = $urandom_range(0, 1);
      ex_branch_out = ex_pred_taken;
      step();
    end
    check_eq("br_count saturated", {16'd0, br_count}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
# branch_pc_ctrl

Next-PC sequencer and branch-resolution controller for the 5-stage RV32I pipeline. It owns the fetch PC. It predicts conditional branches in ID with a direct-mapped 2-bit branch history table (BHT) and redirects on JAL. In EX it takes the comparator result from `branch_unit` and, on a misprediction or JALR, redirects fetch and issues flushes. It also keeps branch and mispredict counters for the VGA debug overlay.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `BHT_ENTRIES`, 16, BHT depth (power of two, 4–64), indexed by `pc[log2(BHT_ENTRIES)+1:2]`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `stall` in 1: hazard-unit stall; holds PC and IF/ID
- `id_valid` in 1: ID holds a real instruction
- `id_brop` in 5: BrOp of the ID instruction
- `id_pc` in 32: PC of the ID instruction
- `id_imm` in 32: B/J immediate of the ID instruction
- `ex_valid` in 1: EX holds a real instruction
- `ex_brop` in 5: BrOp of the EX instruction
- `ex_pc` in 32: PC of the EX instruction
- `ex_imm` in 32: immediate of the EX instruction
- `ex_pred_taken` in 1: prediction piped from ID to EX
- `ex_branch_out` in 1: `branchOut` from `branch_unit`
- `ex_jalr_target` in 32: ALU result for JALR
- `pc` out 32: fetch PC (registered)
- `id_pred_taken` out 1: prediction for the ID instruction; pipe it to `ex_pred_taken`
- `flush_ifid` out 1: squash IF/ID this cycle
- `flush_idex` out 1: squash ID/EX this cycle
- `br_count` out 16: resolved conditional branches, saturating
- `mispred_count` out 16: conditional mispredicts plus JALR redirects, saturating

## Operation
- BrOp classes:
  - conditional = `01xxx` (BEQ/BNE/BLT/BGE/BLTU/BGEU)
  - `10111` = JAL
  - `10101` = JALR
  - `11111` and all other codes = not a branch
- The `ex_redirect` condition holds when `ex_valid` is set and either:
  - the EX instruction is conditional and `ex_branch_out != ex_pred_taken`, or
  - the EX instruction is JALR.
- EX redirect target:
  - conditional, actual taken: `ex_pc + ex_imm`
  - conditional, actual not taken: `ex_pc + 4`
  - JALR: `ex_jalr_target & ~32'h1`
- `id_pred_taken` = `id_valid & ~stall & ~ex_redirect & running & (JAL | (conditional & BHT[idx][1]))`. The ID target is `id_pc + id_imm`.
- Next-PC priority:
  1. `ex_redirect` → EX target; asserts `flush_ifid` and `flush_idex`. Overrides `stall`.
  2. `id_pred_taken` → ID target; asserts `flush_ifid` only.
  3. `stall` → hold.
  4. Otherwise `pc + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- BHT update, on every `ex_valid` conditional (independent of `stall`):
  - taken: counter increments, saturating at 2'b11
  - not taken: counter decrements, saturating at 2'b00
  - JAL, JALR and non-branches never touch the BHT.
- Counters:
  - `br_count` increments on every `ex_valid` conditional.
  - `mispred_count` increments on every `ex_redirect`.
  - Both saturate at 16'hFFFF.
- `running`: 1-bit FSM with states IDLE and RUN.
  - Reset puts it in IDLE.
  - IDLE → RUN on the first clock edge after `rst_n` deasserts.
  - While in IDLE, `pc` holds `RESET_PC` and all flush/predict outputs are 0.

## Timing
- Reset values: `pc` = `RESET_PC`, every BHT entry = 2'b01 (weakly not-taken), both counters = 0, FSM = IDLE. `id_pred_taken`, `flush_ifid` and `flush_idex` read 0 while `rst_n` is low.
- `pc`, BHT and counters update on the rising edge. `id_pred_taken` and the flush outputs are combinational in the same cycle as their cause.
- Redirect penalties:
  - ID-predicted taken branch or JAL: 1 bubble.
  - EX redirect: 2 bubbles.
  - The new PC appears on `pc` one cycle after the cause.
- If the BHT update and the ID read hit the same index in the same cycle, the read returns the pre-update value.
- Reset asserted mid-operation forces all state to reset values immediately; there is no pending redirect after release.

## Structure
- Package `branch_pkg` holds:
  - BrOp localparams: `BR_BEQ`=01000, `BR_BNE`=01001, `BR_BLT`=01100, `BR_BGE`=01101, `BR_BLTU`=01110, `BR_BGEU`=01111, `BR_JAL`=10111, `BR_JALR`=10101, `BR_NONE`=11111
  - `is_cond(brop)` function
  - `bht_ctr_t` (2-bit) typedef and `BHT_RESET` = 2'b01
- Sub-module `branch_bht`: one combinational read port, one synchronous write port, async-reset counter array. The FSM, next-PC mux and counters stay in `branch_pc_ctrl`. `branch_unit` is instantiated outside.

## Test plan
- Reset then 4 cycles with no branches → `pc` sequence 0, 0 (IDLE), 4, 8, 12; all flush outputs 0.
- BEQ at `id_pc`=0x10, `id_imm`=0x20, fresh BHT → `id_pred_taken`=0. In EX with `ex_branch_out`=1 → both flushes, next `pc`=0x30, BHT[4]=2'b10, `mispred_count`=1.
- Same BEQ taken a second time → `id_pred_taken`=1, `flush_ifid` only, `pc`=0x30. In EX, no redirect; BHT[4]=2'b11, saturates on a third taken.
- JAL at 0x40, imm 0x100 → ID redirect to 0x140, no EX redirect. JALR with `ex_jalr_target`=0x203 → `pc`=0x202, both flushes.
- EX mispredict while `stall`=1 and ID holds a JAL → EX target wins, `id_pred_taken`=0, stall ignored.
- `pc` at 0xFFFF_FFFC with no branch → next `pc`=0. Drive 70000 resolved branches → `br_count` holds at 0xFFFF.
